// File: rtl/pio_in_debounced.sv
// Avalon-MM input port: synchronises, debounces and edge-captures external pins, raising irq on masked events.
// Pin to edge_capture takes SYNC_STAGES+2 cycles when debounce is bypassed; the slave never stalls and readdata lags address by one cycle.
module pio_in_debounced #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_DEFAULT = 0,
  parameter int EDGE_TYPE   = 1,
  parameter int IRQ_LEVEL   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_data;
  logic [WIDTH-1:0] stable_data;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] prev_data;
  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clear_bits;
  logic [DEB_W-1:0] threshold;
  logic [DEB_W-1:0] cnt      [WIDTH];
  logic [DEB_W-1:0] cnt_next [WIDTH];
  logic             wr_en;
  logic             mask_wr;
  logic             cap_wr;
  logic             thr_wr;
  logic [31:0]      rd_next;

  assign wr_en      = chipselect & ~write_n;
  assign mask_wr    = wr_en && (address == 3'd2);
  assign cap_wr     = wr_en && (address == 3'd3);
  assign thr_wr     = wr_en && (address == 3'd4);
  assign clear_bits = cap_wr ? writedata[WIDTH-1:0] : '0;
  assign sync_data  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A bit only follows sync_data after disagreeing for threshold consecutive cycles.
  always_comb begin
    stable_next = stable_data;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (threshold == '0) begin
        stable_next[i] = sync_data[i];
      end else if (sync_data[i] != stable_data[i]) begin
        if (cnt[i] == threshold - DEB_W'(1)) begin
          stable_next[i] = sync_data[i];
        end else if (cnt[i] != '1) begin
          cnt_next[i] = cnt[i] + DEB_W'(1);
        end else begin
          cnt_next[i] = cnt[i];
        end
      end
      if (thr_wr) cnt_next[i] = '0;
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_event = stable_data & ~prev_data;
      1:       edge_event = ~stable_data & prev_data;
      default: edge_event = stable_data ^ prev_data;
    endcase
  end

  always_comb begin
    rd_next = '0;
    case (address)
      3'd0:    rd_next = 32'(stable_data);
      3'd1:    rd_next = 32'(sync_data);
      3'd2:    rd_next = 32'(irq_mask);
      3'd3:    rd_next = 32'(edge_capture);
      3'd4:    rd_next = 32'(threshold);
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_data  <= '0;
      prev_data    <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      threshold    <= DEB_W'(DEB_DEFAULT);
      readdata     <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable_data  <= stable_next;
      prev_data    <= stable_data;
      // A new edge wins over a same-cycle clear so no event is lost.
      edge_capture <= (edge_capture & ~clear_bits) | edge_event;
      readdata     <= rd_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
      if (mask_wr) irq_mask <= writedata[WIDTH-1:0];
      if (thr_wr) threshold <= writedata[DEB_W-1:0];
    end
  end

  assign irq = (IRQ_LEVEL != 0) ? |(stable_data & irq_mask) : |(edge_capture & irq_mask);

endmodule
